// File: rtl/type_buffer.sv
// Keystroke-to-text writer: builds the typed-text array and correctness mask for the renderer.
// Optional TYPE_BUFFER_STRICT_EN: mismatched characters are rejected instead of written.
module type_buffer #(
    parameter  int SLOTS = 25,
    parameter  int CNT_W = 16,
    localparam int LW    = $clog2(SLOTS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [5*SLOTS-1:0] target_i,
    input  logic               key_valid_i,
    input  logic [4:0]         key_code_i,
    input  logic               key_bksp_i,
    output logic [5*SLOTS-1:0] type_o,
    output logic [SLOTS-1:0]   correct_o,
    output logic [LW-1:0]      len_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               done_pulse_o,
    output logic [CNT_W-1:0]   key_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        TYPING,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [5*SLOTS-1:0] tgt_q, tgt_d;
    logic [LW-1:0]      tlen_q, tlen_d;
    logic [5*SLOTS-1:0] type_q, type_d;
    logic [SLOTS-1:0]   correct_q, correct_d;
    logic [LW-1:0]      len_q, len_d;
    logic [CNT_W-1:0]   key_cnt_q, key_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               pulse_q, pulse_d;

    logic [LW-1:0]      tlen_start;
    logic [SLOTS-1:0]   tmask;
    logic               key_ok;
    logic               match;
    logic               wr;
    logic               err;

    // Target length is the position of the first empty slot.
    always_comb begin
        tlen_start = LW'(SLOTS);
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (target_i[5*i +: 5] == 5'd0) begin
                tlen_start = LW'(i);
            end
        end
    end

    always_comb begin
        tmask = '0;
        for (int i = 0; i < SLOTS; i++) begin
            tmask[i] = (i < int'(tlen_q));
        end
    end

    assign key_ok = key_valid_i && (key_code_i != 5'd0) &&
                    (key_code_i <= 5'd27) && (len_q < tlen_q);
    assign match  = (key_code_i == tgt_q[5*len_q +: 5]);

`ifdef TYPE_BUFFER_STRICT_EN
    assign wr  = key_ok && match;
    assign err = key_ok && !match;
`else
    assign wr  = key_ok;
    assign err = key_ok && !match;
`endif

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        tlen_d    = tlen_q;
        type_d    = type_q;
        correct_d = correct_q;
        len_d     = len_q;
        key_cnt_d = key_cnt_q;
        err_cnt_d = err_cnt_q;
        pulse_d   = 1'b0;

        if (start_i) begin
            tgt_d     = target_i;
            tlen_d    = tlen_start;
            type_d    = '0;
            correct_d = '0;
            len_d     = '0;
            key_cnt_d = '0;
            err_cnt_d = '0;
            state_d   = TYPING;
        end else if (state_q == TYPING) begin
            if (key_bksp_i) begin
                if (len_q != '0) begin
                    len_d                 = len_q - 1'b1;
                    type_d[5*len_d +: 5]  = 5'd0;
                    correct_d[len_d]      = 1'b0;
                end
            end else begin
                if (wr) begin
                    type_d[5*len_q +: 5] = key_code_i;
                    correct_d[len_q]     = match;
                    len_d                = len_q + 1'b1;
                    if (!(&key_cnt_q)) begin
                        key_cnt_d = key_cnt_q + 1'b1;
                    end
                end
                if (err && !(&err_cnt_q)) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
            // Finished only when every target slot holds the right character.
            if (len_d == tlen_q && (correct_d & tmask) == tmask) begin
                state_d = DONE;
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            tlen_q    <= '0;
            type_q    <= '0;
            correct_q <= '0;
            len_q     <= '0;
            key_cnt_q <= '0;
            err_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            tlen_q    <= tlen_d;
            type_q    <= type_d;
            correct_q <= correct_d;
            len_q     <= len_d;
            key_cnt_q <= key_cnt_d;
            err_cnt_q <= err_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign type_o       = type_q;
    assign correct_o    = correct_q;
    assign len_o        = len_q;
    assign busy_o       = (state_q == TYPING);
    assign done_o       = (state_q == DONE);
    assign done_pulse_o = pulse_q;
    assign key_cnt_o    = key_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_type_buffer.sv
// Scoreboard bench for type_buffer: queue-based reference model, directed and random keystrokes.
module tb_type_buffer;

    localparam int SLOTS = 25;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [5*SLOTS-1:0] target = '0;
    logic               key_valid = 1'b0;
    logic [4:0]         key_code = '0;
    logic               key_bksp = 1'b0;
    logic [5*SLOTS-1:0] type_w;
    logic [SLOTS-1:0]   correct_w;
    logic [4:0]         len_w;
    logic               busy_w;
    logic               done_w;
    logic               dp_w;
    logic [15:0]        kc_w;
    logic [15:0]        ec_w;

    type_buffer #(.SLOTS(SLOTS), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .target_i    (target),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .key_bksp_i  (key_bksp),
        .type_o      (type_w),
        .correct_o   (correct_w),
        .len_o       (len_w),
        .busy_o      (busy_w),
        .done_o      (done_w),
        .done_pulse_o(dp_w),
        .key_cnt_o   (kc_w),
        .err_cnt_o   (ec_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5*SLOTS-1:0] ty;
        logic [SLOTS-1:0]   co;
        logic [4:0]         len;
        logic               busy;
        logic               done;
        logic               dp;
        logic [15:0]        kc;
        logic [15:0]        ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: typed text as a plain list of codes.
    int m_tgt[SLOTS];
    int m_tlen;
    int typed[$];
    int m_kc, m_ec;
    int m_st;
    bit m_pulse;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ty = '0;
        e.co = '0;
        for (int k = 0; k < typed.size(); k++) begin
            e.ty[5*k +: 5] = 5'(typed[k]);
            e.co[k]        = (typed[k] == m_tgt[k]);
        end
        e.len  = 5'(typed.size());
        e.busy = (m_st == 1);
        e.done = (m_st == 2);
        e.dp   = m_pulse;
        e.kc   = 16'(m_kc);
        e.ec   = 16'(m_ec);
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_tlen = 0;
        typed.delete();
        m_kc = 0;
        m_ec = 0;
        m_pulse = 0;
        for (int k = 0; k < SLOTS; k++) m_tgt[k] = 0;
    endtask

    task automatic model_step(bit s, logic [5*SLOTS-1:0] tv, bit kv, int code, bit bk);
        bit mis;
        bit all_ok;
        m_pulse = 0;
        if (s) begin
            for (int k = 0; k < SLOTS; k++) m_tgt[k] = int'(tv[5*k +: 5]);
            m_tlen = SLOTS;
            for (int k = SLOTS - 1; k >= 0; k--) if (m_tgt[k] == 0) m_tlen = k;
            typed.delete();
            m_kc = 0;
            m_ec = 0;
            m_st = 1;
        end else if (m_st == 1) begin
            if (bk) begin
                if (typed.size() > 0) void'(typed.pop_back());
            end else if (kv && code >= 1 && code <= 27 && typed.size() < m_tlen) begin
                mis = (code != m_tgt[typed.size()]);
`ifdef TYPE_BUFFER_STRICT_EN
                if (!mis) begin
                    typed.push_back(code);
                    if (m_kc < 65535) m_kc++;
                end
`else
                typed.push_back(code);
                if (m_kc < 65535) m_kc++;
`endif
                if (mis && m_ec < 65535) m_ec++;
            end
            all_ok = (typed.size() == m_tlen);
            foreach (typed[k]) if (typed[k] != m_tgt[k]) all_ok = 0;
            if (all_ok) begin
                m_st = 2;
                m_pulse = 1;
            end
        end
    endtask

    task automatic cyc(bit s, logic [5*SLOTS-1:0] tv, bit kv, int code, bit bk);
        @(negedge clk);
        start     = s;
        target    = tv;
        key_valid = kv;
        key_code  = 5'(code);
        key_bksp  = bk;
        model_step(s, tv, kv, code, bk);
        exp_q.push_back(model_out());
    endtask

    task automatic key(int c);
        cyc(0, '0, 1, c, 0);
    endtask

    task automatic bksp();
        cyc(0, '0, 0, 0, 1);
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_type"}, type_w, '0);
        chk({tag, "_correct"}, correct_w, '0);
        chk({tag, "_len"}, len_w, '0);
        chk({tag, "_flags"}, {busy_w, done_w, dp_w}, '0);
        chk({tag, "_cnts"}, {kc_w, ec_w}, '0);
    endtask

    // Monitor: every clock the DUT presents a new registered state.
    exp_t e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("type", type_w, e.ty);
            chk("correct", correct_w, e.co);
            chk("len", len_w, e.len);
            chk("busy", busy_w, e.busy);
            chk("done", done_w, e.done);
            chk("done_pulse", dp_w, e.dp);
            chk("key_cnt", kc_w, e.kc);
            chk("err_cnt", ec_w, e.ec);
        end
    end

    logic [5*SLOTS-1:0] cat;
    logic [5*SLOTS-1:0] full;
    logic [5*SLOTS-1:0] empty_t;

    initial begin
        model_reset();
        cat = '0;
        cat[4:0] = 5'd3;
        cat[9:5] = 5'd1;
        cat[14:10] = 5'd20;
        full = '0;
        for (int k = 0; k < SLOTS; k++) full[5*k +: 5] = 5'(1 + (k * 7) % 27);
        empty_t = '0;
        empty_t[9:5] = 5'd4;

        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle();
        key(3);
        bksp();

        // CAT typed correctly
        cyc(1, cat, 0, 0, 0);
        key(3);
        key(1);
        key(20);
        @(posedge clk);
        #2;
        chk("cat_done", {done_w, dp_w, len_w}, {1'b1, 1'b1, 5'd3});
        idle();
        key(5);

        // error then correction
        cyc(1, cat, 0, 0, 0);
        key(3);
        key(2);
        bksp();
        key(1);
        key(20);
        idle();

        // full buffer with errors, extra key, backspace at zero
        cyc(1, cat, 0, 0, 0);
        bksp();
        key(3);
        key(2);
        key(4);
        key(5);
        idle();

        // key and backspace together, start and key together
        cyc(1, cat, 0, 0, 0);
        key(3);
        key(1);
        cyc(0, '0, 1, 3, 1);
        cyc(1, cat, 1, 3, 0);
        idle();

        // full-length phrase
        cyc(1, full, 0, 0, 0);
        for (int k = 0; k < SLOTS; k++) key(int'(full[5*k +: 5]));
        idle();

        // async reset mid-sequence
        cyc(1, full, 0, 0, 0);
        for (int k = 0; k < 10; k++) key(int'(full[5*k +: 5]));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();

        // empty target, reserved code
        cyc(1, empty_t, 0, 0, 0);
        idle();
        idle();
        cyc(1, cat, 0, 0, 0);
        key(28);
        key(31);
        key(0);
        idle();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            int code;
            logic [5*SLOTS-1:0] tv;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                int tl;
                tv = '0;
                tl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SLOTS))
                                                  : int'($urandom_range(0, 6));
                for (int k = 0; k < SLOTS; k++) begin
                    if (k < tl) tv[5*k +: 5] = 5'($urandom_range(1, 27));
                    else if (k == tl) tv[5*k +: 5] = 5'd0;
                    else tv[5*k +: 5] = 5'($urandom_range(0, 31));
                end
                cyc(1, tv, $urandom_range(0, 1), int'($urandom_range(0, 31)), 0);
            end else if (r < 15) begin
                cyc(0, '0, $urandom_range(0, 1), int'($urandom_range(0, 31)), 1);
            end else if (r < 75) begin
                if (typed.size() < m_tlen && $urandom_range(0, 9) < 8)
                    code = m_tgt[typed.size()];
                else
                    code = int'($urandom_range(0, 31));
                key(code);
            end else begin
                idle();
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/type_buffer.md
# type_buffer

Keystroke-to-text writer for the TypeRacer display path. Accepts decoded character and backspace events, builds the 25-slot typed-text array and per-slot correctness mask, and drives the `type`/`correct` inputs of the VGA text renderer. Tracks progress against a target phrase latched at start, and flags completion when the phrase is typed exactly. Keystroke and error counters are provided for the downstream WPM/accuracy logic.

## Interface
- `SLOTS`, 25: character slots; the array width is 5*SLOTS.
- `CNT_W`, 16: width of the keystroke and error counters.

- `clk`  in  1  system clock (100 MHz domain).
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle pulse: latch `target`, clear buffer and counters, enter TYPING.
- `target`  in  5*SLOTS  target phrase; slot i = bits [5i+4:5i]; slot 0 is leftmost.
- `key_valid`  in  1  one-cycle strobe: `key_code` is valid.
- `key_code`  in  5  0 = none; 1..26 = A..Z; 27 = space; 28..31 reserved.
- `key_bksp`  in  1  one-cycle backspace strobe.
- `type`  out  5*SLOTS  typed text, same slot encoding as `target`; empty slots = 0.
- `correct`  out  SLOTS  bit i = 1 iff slot i is written and equals latched target slot i.
- `len`  out  5  number of filled slots, 0..SLOTS.
- `busy`  out  1  high in TYPING.
- `done`  out  1  high in DONE.
- `done_pulse`  out  1  one-cycle pulse on entry to DONE.
- `key_cnt`  out  CNT_W  accepted characters since start; saturates at all-ones.
- `err_cnt`  out  CNT_W  mismatched characters since start; saturates; never decremented.

## Operation
- States: IDLE, TYPING, DONE. Reset puts the block in IDLE with every output 0.
- IDLE/DONE: key and backspace events are ignored. `start` moves the block to TYPING.
- On `start` in any state, the block:
  - latches `target` into `tgt`;
  - computes `tlen` = index of the first zero slot of `tgt` (SLOTS if none);
  - clears `type`, `correct`, `len`, `key_cnt` and `err_cnt`.
- `tlen` = 0 at start: the block goes to DONE on the next cycle.
- TYPING, character with code 1..27 and `len` < `tlen`:
  - writes slot `len`;
  - sets `correct[len]` = (code == `tgt` slot `len`);
  - increments `len` and `key_cnt`;
  - increments `err_cnt` on mismatch.
- TYPING, character ignored when the code is 0 or 28..31, or when `len` == `tlen` (buffer full).
- TYPING, backspace with `len` > 0: decrements `len`, zeroes slot `len-1` and `correct[len-1]`. Counters are unchanged. Backspace with `len` = 0 is ignored.
- Completion: TYPING → DONE when, after the update, `len` == `tlen` and `correct[tlen-1:0]` is all ones. A full buffer containing errors stays in TYPING until the user backspaces.
- Priority within one cycle: `start` > `key_bksp` > `key_valid`. A lower-priority event in the same cycle is dropped.
- `target` is don't-care except in the `start` cycle.

## Timing
- Every output is registered. An event sampled at edge n is visible after edge n (one-cycle latency).
- `done` and `done_pulse` rise on the same edge that writes the final correct character.
- `done_pulse` is high for exactly one cycle. `done` holds until the next `start` or `rst`.
- `rst` asserted mid-operation clears all state immediately, without waiting for `clk`.
- Consecutive-cycle strobes are legal. There is no back-pressure: events arriving while ignored are lost.

## Configuration
- `TYPE_BUFFER_STRICT_EN` defined: a mismatched character is rejected.
  - Slot and `len` are not written.
  - `err_cnt` increments; `key_cnt` does not.
  - `correct[len-1:0]` is therefore always all ones.
- `TYPE_BUFFER_STRICT_EN` undefined: mismatched characters are written with `correct` = 0, as described in Operation.

## Test plan
- Target "CAT" (3,1,20,0…), start, keys 3,1,20 → `len`=3, `correct`=3'b111, `done_pulse` one cycle on the third write; `key_cnt`=3, `err_cnt`=0.
- Target "CAT", keys 3,2 → `correct[1]`=0 and `err_cnt`=1. Then bksp, 1, 20 → DONE; `key_cnt`=4, `err_cnt`=1. Strict build: key 2 is rejected (`len` stays 1).
- Target "CAT", keys 3,2,4 (buffer full) → stays TYPING. A further key 5 is ignored (`len`=3). Bksp at `len`=0 is ignored.
- `key_valid` (code 3) and `key_bksp` in the same cycle at `len`=2 → `len`=1, slot 1 = 0. `start` and key in the same cycle → buffer cleared, `len`=0.
- Full 25-char target, all typed correctly → DONE at `len`=25. Assert `rst` mid-sequence at `len`=10 → all outputs 0 before the next `clk` edge, state IDLE.
- Target with slot 0 = 0 → DONE one cycle after `start`. Code 28 in TYPING is ignored.
